// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//    Shared types and constants for the two-port memory arbiter.
//    - state_t   : transaction FSM states (3-bit encoding)
//    - PORT_CPU  : index of the 6502 core bus port
//    - PORT_AUX  : index of the loader / debug DMA port
//    - rr_winner : tie-break helper for the round-robin build
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      SETTLE = 3'd2,
      WAIT   = 3'd3,
      ACK    = 3'd4
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   // On a tie the port that was not granted last wins; otherwise the
   // only requester wins.
   function automatic logic rr_winner(input logic req0, input logic req1,
                                      input logic last_grant);
      if (req0 && req1) begin
         return ~last_grant;
      end
      return req1 && !req0;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//    Serialises whole read/write transactions from two requesters onto the
//    single memc command interface and returns per-port ack and read data.
//    Every transaction walks IDLE -> ISSUE -> SETTLE -> WAIT -> ACK.
//
// Ports:
//    clk, reset                 : clock, synchronous active-high reset
//    pX_req/we/addr/wr_data     : port X request (level, held until pX_ack)
//    pX_ack                     : one-cycle completion pulse for port X
//    pX_rd_data                 : last read data returned to port X
//    mem_rd_enable/wr_enable    : one-cycle memc strobes (never both)
//    mem_addr/mem_wr_data       : latched command, held until next ISSUE
//    mem_busy/mem_rd_data       : memc status and read return
//    arb_owner                  : port owning the current/last transaction
//
// Build option:
//    MEM_ARB_ROUND_ROBIN_EN : ties go to the port not granted last
//                             (otherwise port 0 always wins a tie).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wr_data,
   output logic                  p0_ack,
   output logic [DATA_WIDTH-1:0] p0_rd_data,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wr_data,
   output logic                  p1_ack,
   output logic [DATA_WIDTH-1:0] p1_rd_data,
   output logic                  mem_rd_enable,
   output logic                  mem_wr_enable,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic                  mem_busy,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  arb_owner
);

   state_t                state_reg, state_next;
   logic                  owner_reg;
   logic                  we_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0] wr_data_reg;
   logic [DATA_WIDTH-1:0] rd_data_reg [2];
   logic [1:0]            ack_vec;
   logic                  grant;
   logic                  capture;
   logic                  winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_grant_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_reg <= 1'b0;
      end else if (grant) begin
         last_grant_reg <= winner;
      end
   end

   assign winner = rr_winner(p0_req, p1_req, last_grant_reg);
`else
   assign winner = p0_req ? PORT_CPU : PORT_AUX;
`endif

   // Next-state logic; grant and capture are the only side-effect strobes.
   always_comb begin
      state_next = state_reg;
      grant      = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!mem_busy && (p0_req || p1_req)) begin
               grant      = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE:  state_next = SETTLE;
         // memc may not have raised busy yet, so busy is ignored here.
         SETTLE: state_next = WAIT;
         WAIT: begin
            if (!mem_busy) begin
               capture    = 1'b1;
               state_next = ACK;
            end
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         owner_reg   <= PORT_CPU;
         we_reg      <= 1'b0;
         addr_reg    <= '0;
         wr_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         // Command is latched at grant so mem_addr/mem_wr_data change only
         // as ISSUE starts and hold until the next ISSUE.
         if (grant) begin
            owner_reg   <= winner;
            we_reg      <= winner ? p1_we : p0_we;
            addr_reg    <= winner ? p1_addr : p0_addr;
            wr_data_reg <= winner ? p1_wr_data : p0_wr_data;
         end
      end
   end

   // Per-port read data registers and ack decode.
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      always_ff @(posedge clk) begin
         if (reset) begin
            rd_data_reg[gi] <= '0;
         end else if (capture && !we_reg && (owner_reg == (gi == 1))) begin
            rd_data_reg[gi] <= mem_rd_data;
         end
      end
      assign ack_vec[gi] = (state_reg == ACK) && (owner_reg == (gi == 1));
   end

   // Strobes are decoded from the single ISSUE state, so they are one cycle
   // wide and mutually exclusive by construction.
   assign mem_rd_enable = (state_reg == ISSUE) && !we_reg;
   assign mem_wr_enable = (state_reg == ISSUE) && we_reg;
   assign mem_addr      = addr_reg;
   assign mem_wr_data   = wr_data_reg;
   assign p0_ack        = ack_vec[0];
   assign p1_ack        = ack_vec[1];
   assign p0_rd_data    = rd_data_reg[0];
   assign p1_rd_data    = rd_data_reg[1];
   assign arb_owner     = owner_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//    Directed bench for mem_arbiter with a small memc model (byte memory,
//    programmable busy length after each strobe, forced busy override).
//    Build with MEM_ARB_ROUND_ROBIN_EN to check the round-robin tie order.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [15:0] p0_addr, p1_addr;
   logic [7:0]  p0_wr_data, p1_wr_data;
   logic        p0_ack, p1_ack;
   logic [7:0]  p0_rd_data, p1_rd_data;
   logic        mem_rd_enable, mem_wr_enable;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wr_data;
   logic        mem_busy;
   logic [7:0]  mem_rd_data;
   logic        arb_owner;

   int n_checks = 0;
   int n_fail   = 0;

   // memc model controls
   logic        force_busy = 1'b0;
   int          busy_len   = 0;
   logic        preload_en = 1'b0;
   logic [15:0] preload_addr = '0;
   logic [7:0]  preload_data = '0;

   // memc model state and monitors
   logic [7:0]  mem_model [0:65535];
   int          busy_cnt = 0;
   int          rd_cnt   = 0;
   int          wr_cnt   = 0;
   int          both_cnt = 0;
   int          ack0_cnt = 0;
   int          ack1_cnt = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
      .p0_ack(p0_ack), .p0_rd_data(p0_rd_data),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
      .p1_ack(p1_ack), .p1_rd_data(p1_rd_data),
      .mem_rd_enable(mem_rd_enable), .mem_wr_enable(mem_wr_enable),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_busy(mem_busy), .mem_rd_data(mem_rd_data),
      .arb_owner(arb_owner)
   );

   assign mem_busy = force_busy || (busy_cnt != 0);

   always @(posedge clk) begin
      if (preload_en) mem_model[preload_addr] <= preload_data;
      if (mem_wr_enable) mem_model[mem_addr] <= mem_wr_data;
      if (mem_rd_enable) mem_rd_data <= mem_model[mem_addr];
      if (mem_rd_enable || mem_wr_enable) busy_cnt <= busy_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (mem_rd_enable) rd_cnt <= rd_cnt + 1;
      if (mem_wr_enable) wr_cnt <= wr_cnt + 1;
      if (mem_rd_enable && mem_wr_enable) both_cnt <= both_cnt + 1;
      if (p0_ack) ack0_cnt <= ack0_cnt + 1;
      if (p1_ack) ack1_cnt <= ack1_cnt + 1;
   end

   // Waits (bounded) for the next ack; returns at the negedge of the ack cycle.
   task automatic wait_ack(input int max_cycles, output int cycles, output logic timed_out);
      cycles    = 0;
      timed_out = 1'b1;
      while (cycles < max_cycles) begin
         @(negedge clk);
         cycles++;
         if (p0_ack || p1_ack) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      preload_addr = a;
      preload_data = d;
      preload_en   = 1'b1;
      @(negedge clk);
      preload_en   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      p0_req = 0; p0_we = 0; p0_addr = '0; p0_wr_data = '0;
      p1_req = 0; p1_we = 0; p1_addr = '0; p1_wr_data = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({p0_ack, p1_ack, mem_rd_enable, mem_wr_enable, arb_owner} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 00000",
                  {p0_ack, p1_ack, mem_rd_enable, mem_wr_enable, arb_owner});
      end
      n_checks++;
      if ({mem_addr, mem_wr_data, p0_rd_data, p1_rd_data} !== 40'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wr_data, p0_rd_data, p1_rd_data});
      end
      reset = 1'b0;
      @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_single_read();
      int cyc;
      logic to;
      preload(16'h00FF, 8'hA5);
      p0_we = 0; p0_addr = 16'h00FF; p0_req = 1;
      @(negedge clk);
      n_checks++;
      if ({mem_rd_enable, mem_wr_enable, mem_addr} !== {2'b10, 16'h00FF}) begin
         n_fail++;
         $display("FAIL single_strobe: got rd=%b wr=%b addr=%h required rd=1 wr=0 addr=00ff",
                  mem_rd_enable, mem_wr_enable, mem_addr);
      end
      wait_ack(50, cyc, to);
      n_checks++;
      if (to || cyc != 3 || p0_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ack: got cycles=%0d timeout=%b p0_ack=%b required cycles=3 p0_ack=1", cyc, to, p0_ack);
      end
      p0_req = 0;
      n_checks++;
      if (p0_rd_data !== 8'hA5 || arb_owner !== 1'b0) begin
         n_fail++;
         $display("FAIL single_data: got data=%h owner=%b required a5/0", p0_rd_data, arb_owner);
      end
      @(negedge clk);
      $display("test_single_read p0 rd 00ff -> %h", p0_rd_data);
   endtask

   task automatic test_write_read();
      int cyc;
      logic to;
      int rd0, wr0, a0;
      rd0 = rd_cnt; wr0 = wr_cnt; a0 = ack0_cnt;
      p1_we = 1; p1_addr = 16'h1234; p1_wr_data = 8'h3C; p1_req = 1;
      wait_ack(50, cyc, to);
      p1_req = 0;
      n_checks++;
      if (to || p1_ack !== 1'b1 || arb_owner !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_ack: got timeout=%b p1_ack=%b owner=%b required 0/1/1", to, p1_ack, arb_owner);
      end
      n_checks++;
      if (wr_cnt - wr0 != 1 || rd_cnt != rd0 || mem_addr !== 16'h1234 || mem_wr_data !== 8'h3C) begin
         n_fail++;
         $display("FAIL wr_cmd: got wr=%0d rd=%0d addr=%h data=%h required 1/0/1234/3c",
                  wr_cnt - wr0, rd_cnt - rd0, mem_addr, mem_wr_data);
      end
      n_checks++;
      if (p1_rd_data !== 8'h00) begin
         n_fail++;
         $display("FAIL wr_rd_hold: got p1_rd_data=%h required 00", p1_rd_data);
      end
      @(negedge clk);
      p1_we = 0; p1_req = 1;
      wait_ack(50, cyc, to);
      p1_req = 0;
      n_checks++;
      if (to || p1_ack !== 1'b1 || p1_rd_data !== 8'h3C) begin
         n_fail++;
         $display("FAIL rd_back: got timeout=%b p1_ack=%b data=%h required 0/1/3c", to, p1_ack, p1_rd_data);
      end
      n_checks++;
      if (ack0_cnt != a0) begin
         n_fail++;
         $display("FAIL p0_quiet: got %0d p0 acks required 0", ack0_cnt - a0);
      end
      @(negedge clk);
      $display("test_write_read p1 wr 1234=3c, rd -> %h", p1_rd_data);
   endtask

   task automatic test_slow_mem();
      int cyc;
      logic to;
      int rd0;
      rd0 = rd_cnt;
      busy_len = 10;
      p0_we = 0; p0_addr = 16'h00FF; p0_req = 1;
      wait_ack(50, cyc, to);
      p0_req = 0;
      busy_len = 0;
      n_checks++;
      if (to || cyc != 13 || p0_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL slow_ack: got cycles=%0d timeout=%b p0_ack=%b required 13/0/1", cyc, to, p0_ack);
      end
      n_checks++;
      if (rd_cnt - rd0 != 1) begin
         n_fail++;
         $display("FAIL slow_strobes: got %0d required 1", rd_cnt - rd0);
      end
      @(negedge clk);
      $display("test_slow_mem ack after %0d cycles", cyc);
   endtask

   task automatic test_busy_idle();
      int cyc;
      logic to;
      int rd0;
      preload(16'h0077, 8'h5A);
      rd0 = rd_cnt;
      force_busy = 1;
      p0_we = 0; p0_addr = 16'h0077; p0_req = 1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (rd_cnt != rd0 || mem_rd_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_hold: got strobes=%0d required 0", rd_cnt - rd0);
      end
      force_busy = 0;
      @(negedge clk);
      n_checks++;
      if (mem_rd_enable !== 1'b1 || mem_addr !== 16'h0077) begin
         n_fail++;
         $display("FAIL busy_release: got rd=%b addr=%h required 1/0077", mem_rd_enable, mem_addr);
      end
      wait_ack(50, cyc, to);
      p0_req = 0;
      n_checks++;
      if (to || cyc != 3 || p0_rd_data !== 8'h5A) begin
         n_fail++;
         $display("FAIL busy_done: got cycles=%0d timeout=%b data=%h required 3/0/5a", cyc, to, p0_rd_data);
      end
      @(negedge clk);
      $display("test_busy_idle p0 rd 0077 -> %h", p0_rd_data);
   endtask

   task automatic test_reset_mid();
      int cyc;
      logic to;
      int a0;
      busy_len = 6;
      p0_we = 0; p0_addr = 16'h0042; p0_req = 1;
      repeat (3) @(negedge clk);   // now in WAIT with memc busy
      reset = 1; p0_req = 0;
      a0 = ack0_cnt;
      @(negedge clk);
      n_checks++;
      if ({p0_ack, p1_ack, mem_rd_enable, mem_wr_enable, arb_owner} !== 5'b0 ||
          {mem_addr, mem_wr_data, p0_rd_data, p1_rd_data} !== 40'h0) begin
         n_fail++;
         $display("FAIL mid_reset: got ctrl=%b data=%h required all 0",
                  {p0_ack, p1_ack, mem_rd_enable, mem_wr_enable, arb_owner},
                  {mem_addr, mem_wr_data, p0_rd_data, p1_rd_data});
      end
      reset = 0;
      busy_len = 0;
      repeat (8) @(negedge clk);
      n_checks++;
      if (ack0_cnt != a0) begin
         n_fail++;
         $display("FAIL mid_no_ack: got %0d acks required 0", ack0_cnt - a0);
      end
      p0_addr = 16'h00FF; p0_req = 1;
      wait_ack(50, cyc, to);
      p0_req = 0;
      n_checks++;
      if (to || cyc != 4 || p0_ack !== 1'b1 || p0_rd_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL mid_fresh: got cycles=%0d timeout=%b ack=%b data=%h required 4/0/1/a5",
                  cyc, to, p0_ack, p0_rd_data);
      end
      @(negedge clk);
      $display("test_reset_mid fresh rd -> %h", p0_rd_data);
   endtask

   task automatic test_contention();
      int cyc;
      logic to;
      logic exp_seq [4];
      logic got;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      preload(16'h0010, 8'h11);
      preload(16'h0020, 8'h22);
      p0_we = 0; p0_addr = 16'h0010;
      p1_we = 0; p1_addr = 16'h0020;
      p0_req = 1; p1_req = 1;
      for (int i = 0; i < 4; i++) begin
         wait_ack(50, cyc, to);
         got = p1_ack;
         if (i == 3) p0_req = 0;
         n_checks++;
         if (to || (p0_ack && p1_ack) || got !== exp_seq[i] || arb_owner !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL tie_grant%0d: got p0_ack=%b p1_ack=%b owner=%b timeout=%b required owner %b",
                     i, p0_ack, p1_ack, arb_owner, to, exp_seq[i]);
         end
         $display("tie grant %0d -> port %0d", i, got);
      end
      wait_ack(50, cyc, to);
      p1_req = 0;
      n_checks++;
      if (to || p1_ack !== 1'b1 || p1_rd_data !== 8'h22 || arb_owner !== 1'b1) begin
         n_fail++;
         $display("FAIL tie_p1_last: got p1_ack=%b data=%h owner=%b timeout=%b required 1/22/1",
                  p1_ack, p1_rd_data, arb_owner, to);
      end
      n_checks++;
      if (p0_rd_data !== 8'h11) begin
         n_fail++;
         $display("FAIL tie_p0_data: got %h required 11", p0_rd_data);
      end
      @(negedge clk);
      n_checks++;
      if (both_cnt != 0) begin
         n_fail++;
         $display("FAIL dual_strobe: got %0d cycles required 0", both_cnt);
      end
      $display("test_contention done");
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_read();
      test_slow_mem();
      test_busy_idle();
      test_reset_mid();
      test_contention();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
